// File: rtl/bp_pkg.sv
// Shared branch-predictor types and the 2-bit saturating counter step.
// Reused by every predictor table that holds 2-bit direction counters.
package bp_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_RESET = 2'b01;

    function automatic ctr2_t ctr_update(ctr2_t c, logic taken);
        ctr2_t r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'b01;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/gshare_pht_sat_counter2.sv
// Single 2-bit saturating direction counter, async reset to weakly not-taken.
// One instance per PHT entry.
module sat_counter2
    import bp_pkg::*;
(
    input  logic  clk,
    input  logic  areset,
    input  logic  i_en,
    input  logic  i_taken,
    output ctr2_t o_ctr
);

    ctr2_t r_ctr;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_ctr <= CTR_RESET;
        end else if (i_en) begin
            r_ctr <= ctr_update(r_ctr, i_taken);
        end
    end

    assign o_ctr = r_ctr;

endmodule

// File: rtl/gshare_pht.sv
// gshare pattern history table: PC^history indexed 2-bit counters,
// combinational lookup, edge-applied training, saturating mispredict stats.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int INDEX_W = 7,
    parameter int HIST_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               predict_valid,
    input  logic [INDEX_W-1:0] predict_pc,
    input  logic [HIST_W-1:0]  predict_history,
    output logic               predict_taken,
    output logic [INDEX_W-1:0] predict_index,
    input  logic               train_valid,
    input  logic               train_taken,
    input  logic               train_mispredicted,
    input  logic [INDEX_W-1:0] train_pc,
    input  logic [HIST_W-1:0]  train_history,
    output logic [CNT_W-1:0]   mispredict_count
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [INDEX_W-1:0] w_predict_index;
    logic [INDEX_W-1:0] w_train_index;
    logic [DEPTH-1:0]   w_taken_bit;
    logic               w_unused;
    logic [CNT_W-1:0]   r_miss;

    assign w_predict_index = predict_pc ^ predict_history[INDEX_W-1:0];
    assign w_train_index   = train_pc ^ train_history[INDEX_W-1:0];

    // Upper history bits only exist for compatibility with the history register.
    assign w_unused = ^{predict_history[HIST_W-1:INDEX_W],
                        train_history[HIST_W-1:INDEX_W]};

    for (genvar i = 0; i < DEPTH; i++) begin : g_pht
        ctr2_t w_ctr;
        logic  w_en;

        assign w_en = train_valid && (w_train_index == INDEX_W'(i));

        sat_counter2 u_ctr (
            .clk     (clk),
            .areset  (areset),
            .i_en    (w_en),
            .i_taken (train_taken),
            .o_ctr   (w_ctr)
        );

        assign w_taken_bit[i] = w_ctr[1];
    end

    // Gate with valid so an X index while idle still yields a clean 0.
    assign predict_taken = predict_valid & w_taken_bit[w_predict_index];
    assign predict_index = w_predict_index;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_miss <= '0;
        end else if (train_valid && train_mispredicted && (r_miss != '1)) begin
            r_miss <= r_miss + CNT_W'(1);
        end
    end

    assign mispredict_count = r_miss;

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed cases plus a randomized run
// compared every cycle against an array-of-integers reference model.
module tb_gshare_pht;

    localparam int INDEX_W = 7;
    localparam int HIST_W  = 32;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 1 << INDEX_W;

    logic               clk = 1'b0;
    logic               areset = 1'b1;
    logic               predict_valid = 1'b0;
    logic [INDEX_W-1:0] predict_pc = '0;
    logic [HIST_W-1:0]  predict_history = '0;
    logic               predict_taken;
    logic [INDEX_W-1:0] predict_index;
    logic               train_valid = 1'b0;
    logic               train_taken = 1'b0;
    logic               train_mispredicted = 1'b0;
    logic [INDEX_W-1:0] train_pc = '0;
    logic [HIST_W-1:0]  train_history = '0;
    logic [CNT_W-1:0]   mispredict_count;

    gshare_pht #(
        .INDEX_W (INDEX_W),
        .HIST_W  (HIST_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                (clk),
        .areset             (areset),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_history    (predict_history),
        .predict_taken      (predict_taken),
        .predict_index      (predict_index),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_pc           (train_pc),
        .train_history      (train_history),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counters as plain integers 0..3, stats as integer.
    int m_pht [DEPTH];
    int m_cnt;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
            m_cnt = 0;
        end else if (train_valid) begin
            int idx;
            idx = int'(train_pc) ^ int'(train_history[INDEX_W-1:0]);
            if (train_taken) m_pht[idx] = (m_pht[idx] < 3) ? m_pht[idx] + 1 : 3;
            else             m_pht[idx] = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
            if (train_mispredicted && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!areset) begin
            if (predict_valid) begin
                int idx;
                idx = int'(predict_pc) ^ int'(predict_history[INDEX_W-1:0]);
                check("model_index", int'(predict_index), idx);
                check("model_taken", int'(predict_taken), (m_pht[idx] >= 2) ? 1 : 0);
            end else begin
                check("idle_taken", int'(predict_taken), 0);
            end
            check("model_count", int'(mispredict_count), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_train();
        train_valid        = 1'b0;
        train_taken        = 1'bx;
        train_mispredicted = 1'bx;
        train_pc           = 'x;
        train_history      = 'x;
    endtask

    task automatic lookup(input logic [INDEX_W-1:0] pc, input logic [HIST_W-1:0] h);
        predict_valid   = 1'b1;
        predict_pc      = pc;
        predict_history = h;
    endtask

    task automatic train(input logic [INDEX_W-1:0] pc, input logic [HIST_W-1:0] h,
                         input logic tk, input logic mp);
        train_valid        = 1'b1;
        train_pc           = pc;
        train_history      = h;
        train_taken        = tk;
        train_mispredicted = mp;
    endtask

    initial begin
        idle_train();
        #12 areset = 1'b0;
        #1;

        // Reset state lookup.
        lookup(7'h05, 32'h0);
        @(negedge clk);
        check("rst_taken", int'(predict_taken), 0);
        check("rst_index", int'(predict_index), 32'h05);
        check("rst_count", int'(mispredict_count), 0);
        check("rst_model", m_pht[7'h05], 1);

        // One taken train moves 01 -> 10.
        tick();
        train(7'h05, 32'h0, 1'b1, 1'b1);
        tick();
        idle_train();
        @(negedge clk);
        check("train1_taken", int'(predict_taken), 1);
        check("train1_count", int'(mispredict_count), 1);
        check("train1_model", m_pht[7'h05], 2);

        // Saturate at 11, then one not-taken still predicts taken.
        tick();
        train(7'h05, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        check("sat_model", m_pht[7'h05], 3);
        train(7'h05, 32'h0, 1'b0, 1'b0);
        tick();
        idle_train();
        @(negedge clk);
        check("sat_nt_taken", int'(predict_taken), 1);
        check("sat_nt_model", m_pht[7'h05], 2);

        // Aliasing: 0F^05 == 05^0F == 0A^00 == 0A.
        tick();
        train(7'h0F, 32'h0000_0005, 1'b1, 1'b0);
        lookup(7'h0A, 32'h0);
        @(negedge clk);
        check("alias_pre", int'(predict_taken), 0);
        tick();
        idle_train();
        lookup(7'h05, 32'h0000_000F);
        @(negedge clk);
        check("alias_a_index", int'(predict_index), 32'h0A);
        check("alias_a_taken", int'(predict_taken), 1);
        tick();
        lookup(7'h0A, 32'h0);
        @(negedge clk);
        check("alias_b_taken", int'(predict_taken), 1);

        // Same-cycle predict and train of one index: no bypass.
        tick();
        lookup(7'h22, 32'h0);
        train(7'h22, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("same_old", int'(predict_taken), 0);
        tick();
        idle_train();
        @(negedge clk);
        check("same_new", int'(predict_taken), 1);

        // Randomized run; unused inputs driven X.
        for (int c = 0; c < 2000; c++) begin
            tick();
            if ($urandom_range(0, 3) != 0) begin
                predict_valid   = 1'b1;
                predict_pc      = INDEX_W'($urandom_range(0, 15));
                predict_history = {$urandom};
            end else begin
                predict_valid   = 1'b0;
                predict_pc      = 'x;
                predict_history = 'x;
            end
            if ($urandom_range(0, 1) != 0) begin
                train(INDEX_W'($urandom_range(0, 15)), {$urandom},
                      1'($urandom), 1'($urandom));
            end else begin
                idle_train();
            end
        end

        // Drive the statistics counter into saturation.
        for (int c = 0; c < 70000; c++) begin
            tick();
            train(INDEX_W'($urandom), {$urandom}, 1'($urandom), 1'b1);
        end
        tick();
        idle_train();
        @(negedge clk);
        check("cnt_sat", int'(mispredict_count), CNT_MAX);

        // Asynchronous reset mid-period clears everything before any edge.
        @(posedge clk);
        #2;
        areset = 1'b1;
        #1;
        check("arst_count", int'(mispredict_count), 0);
        for (int i = 0; i < DEPTH; i++) begin
            lookup(INDEX_W'(i), 32'h0);
            #0.1;
            check("arst_pht", int'(predict_taken), 0);
        end
        #5 areset = 1'b0;
        predict_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
